// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: destination scoreboard
// for EX/MEM/WB, operand forwarding selects, load-use stall and taken-branch flush.

module pipeline_hazard_ctrl_fwd #(
  parameter int RW = 5
) (
  input  logic               use_i,
  input  logic [RW-1:0]      rs_i,
  input  logic [2:0]         v_i,
  input  logic [2:0][RW-1:0] rd_i,
  input  logic               ld_ex_i,
  output logic [1:0]         fwd_o,
  output logic               lu_o
);
  logic [2:0] hit;

  // Entry 0 is EX, 1 is MEM, 2 is WB; r0 never forwards.
  always_comb begin
    for (int k = 0; k < 3; k++)
      hit[k] = use_i && v_i[k] && (rd_i[k] == rs_i) && (rs_i != {RW{1'b0}});
  end

  assign lu_o = hit[0] & ld_ex_i;

  // A load still in EX has no data yet; the operand is picked up from MEM after the stall.
  always_comb begin
    fwd_o = 2'b00;
    if (hit[0])      fwd_o = ld_ex_i ? 2'b00 : 2'b01;
    else if (hit[1]) fwd_o = 2'b10;
    else if (hit[2]) fwd_o = 2'b11;
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int RW = 5,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          HOLD,
  input  logic [RW-1:0] ID_RA,
  input  logic [RW-1:0] ID_RB,
  input  logic          ID_USE_RA,
  input  logic          ID_USE_RB,
  input  logic [RW-1:0] ID_RD,
  input  logic          ID_RF_LE,
  input  logic          ID_L,
  input  logic          BR_TAKEN,
  output logic          LE_PC,
  output logic          LE_IFID,
  output logic          NOP_SEL,
  output logic          FLUSH_IF,
  output logic [1:0]    FWD_A,
  output logic [1:0]    FWD_B,
  output logic [CW-1:0] STALL_CNT,
  output logic [1:0]    STATE
);
  typedef enum logic [1:0] {S_FILL = 2'b00, S_RUN = 2'b01, S_FROZEN = 2'b10} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sb_v_q;
  logic [2:0][RW-1:0] sb_rd_q;
  logic               sb_ld_q;   // only the EX entry's load flag is ever consulted
  logic [CW-1:0]      cnt_q;

  logic [1:0]         use_s;
  logic [1:0][RW-1:0] rs_s;
  logic [1:0][1:0]    fwd_s;
  logic [1:0]         lu_s;
  logic               lu, frozen, stall;

  assign use_s = {ID_USE_RB, ID_USE_RA};
  assign rs_s  = {ID_RB, ID_RA};

  for (genvar g = 0; g < 2; g++) begin : g_src
    pipeline_hazard_ctrl_fwd #(.RW(RW)) u_fwd (
      .use_i   (use_s[g]),
      .rs_i    (rs_s[g]),
      .v_i     (sb_v_q),
      .rd_i    (sb_rd_q),
      .ld_ex_i (sb_ld_q),
      .fwd_o   (fwd_s[g]),
      .lu_o    (lu_s[g])
    );
  end

  assign lu     = |lu_s;
  assign frozen = (state_q == S_FROZEN) || (state_q == S_RUN && HOLD);
  assign stall  = (state_q == S_RUN) && !HOLD && lu;

  always_comb begin
    LE_PC    = 1'b0;
    LE_IFID  = 1'b0;
    NOP_SEL  = 1'b0;
    FLUSH_IF = 1'b0;
    FWD_A    = fwd_s[0];
    FWD_B    = fwd_s[1];
    case (state_q)
      S_FILL: begin
        LE_PC   = 1'b1;
        LE_IFID = 1'b1;
        NOP_SEL = 1'b1;
        FWD_A   = 2'b00;
        FWD_B   = 2'b00;
      end
      S_RUN: begin
        if (!HOLD) begin
          if (lu) begin
            NOP_SEL = 1'b1;
          end else begin
            LE_PC    = 1'b1;
            LE_IFID  = 1'b1;
            FLUSH_IF = BR_TAKEN;
          end
        end
      end
      default: ;
    endcase
  end

  // Every state leaves to FROZEN under HOLD and to RUN otherwise.
  always_comb state_d = HOLD ? S_FROZEN : S_RUN;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_FILL;
      sb_v_q  <= '0;
      sb_rd_q <= '0;
      sb_ld_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!frozen) begin
        sb_v_q  <= {sb_v_q[1:0], ID_RF_LE & ~NOP_SEL};
        sb_rd_q <= {sb_rd_q[1:0], (NOP_SEL ? {RW{1'b0}} : ID_RD)};
        sb_ld_q <= ID_L & ~NOP_SEL;
      end
      if (stall && cnt_q != {CW{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign STALL_CNT = cnt_q;
  assign STATE     = state_q;
endmodule
